// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the sequential mantissa multiplier.
package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned ROUND_TRUNC = 0;
  localparam int unsigned ROUND_RNE   = 1;

  // Legal shift-add step: 1, 2 or 4 bits, and it must divide the operand width.
  function automatic bit step_ok(input int unsigned step, input int unsigned width);
    return ((step == 1) || (step == 2) || (step == 4)) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/multiplicador_redondeo.sv
// Combinational normalise + round of the full 2*WIDTH product to OUT_W bits.
module multiplicador_redondeo
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned ROUND = ROUND_RNE
) (
  input  logic [2*WIDTH-1:0] p,
  output logic [OUT_W-1:0]   r,
  output logic               norm,
  output logic               zero
);

  localparam int unsigned PW = 2 * WIDTH;
  // Guard bit position inside {q, 1'b0}; everything below it is sticky.
  localparam int unsigned GI = PW - OUT_W;

  logic [PW-1:0]  q;
  logic [PW:0]    q_ext;
  logic [OUT_W-1:0] r_trunc;
  logic           guard;
  logic           sticky;
  logic           inc;
  logic [OUT_W:0] sum;

  // Align the leading one to the top, pick R/guard/sticky and apply RNE.
  always_comb begin
    q       = p[PW-1] ? p : (p << 1);
    q_ext   = {q, 1'b0};
    r_trunc = q[PW-1 -: OUT_W];
    guard   = q_ext[GI];
    sticky  = |q_ext[GI-1:0];
    inc     = (ROUND == ROUND_RNE) && guard && (sticky || r_trunc[0]);
    sum     = {1'b0, r_trunc} + (OUT_W+1)'(inc);
    zero    = (p == '0);
    norm    = p[PW-1] | sum[OUT_W];
    r       = sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : sum[OUT_W-1:0];
    if (zero) begin
      norm = 1'b0;
      r    = '0;
    end
  end

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential shift-add unsigned mantissa multiplier with valid/ready on both sides.
module multiplicador_seq
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned ROUND = ROUND_RNE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             norm,
  output logic             zero
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned ITER  = WIDTH / STEP;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  // Reject illegal parameterisations at elaboration.
  if (!step_ok(STEP, WIDTH)) begin : g_bad_step
    $error("multiplicador_seq: STEP must be 1, 2 or 4 and divide WIDTH");
  end
  if ((OUT_W < 2) || (OUT_W > PW - 1)) begin : g_bad_out_w
    $error("multiplicador_seq: OUT_W must lie in [2, 2*WIDTH-1]");
  end

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    pp;
  logic             calc_last;
  logic [OUT_W-1:0] r_c;
  logic             norm_c;
  logic             zero_c;

  // Partial product for the STEP multiplier bits retired this cycle.
  always_comb begin
    pp        = mcand * PW'(mplier[STEP-1:0]);
    calc_last = (cnt == CNT_W'(ITER - 1));
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = CALC;
      CALC:    if (calc_last) state_n = NORM;
      NORM:    state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  // Operand capture and shift-add accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= PW'(in1);
            mplier <= in2;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc + pp;
          mcand  <= mcand << STEP;
          mplier <= mplier >> STEP;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  multiplicador_redondeo #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W),
    .ROUND (ROUND)
  ) u_redondeo (
    .p    (acc),
    .r    (r_c),
    .norm (norm_c),
    .zero (zero_c)
  );

  // Result registers, loaded once in NORM and held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      norm <= 1'b0;
      zero <= 1'b0;
    end else if (state == NORM) begin
      out  <= r_c;
      norm <= norm_c;
      zero <= zero_c;
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench: behavioural product/round model, cycle-level handshake model, directed and random stimulus.
module tb_multiplicador_seq;

  localparam int unsigned W       = 24;
  localparam int unsigned OW      = 32;
  localparam int unsigned LAT     = W + 1;
  localparam int unsigned ALT_LAT = W / 4 + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, norm, zero;
  logic [W-1:0]  in1, in2;
  logic [OW-1:0] out;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_norm, a_zero;
  logic [W-1:0]  a_in1, a_in2;
  logic [OW-1:0] a_out;

  int checks = 0;
  int errors = 0;

  multiplicador_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .norm(norm), .zero(zero)
  );

  multiplicador_seq #(.WIDTH(24), .OUT_W(32), .STEP(4), .ROUND(0)) dut_alt (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in1(a_in1), .in2(a_in2), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_out), .norm(a_norm), .zero(a_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Product -> normalised/rounded result, by plain integer arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit rne,
                                output logic [OW-1:0] r, output bit n, output bit z);
    longint unsigned p, q, rem, half;
    int unsigned sh;
    p = 64'(a) * 64'(b);
    z = (p == 0);
    n = 1'b0;
    r = '0;
    if (!z) begin
      n    = (p >= (64'd1 << (2*W-1)));
      sh   = n ? (2*W - OW) : (2*W - OW - 1);
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rne && ((rem > half) || ((rem == half) && ((q % 2) == 1)))) q = q + 1;
      if (q == (64'd1 << OW)) begin
        q = 64'd1 << (OW - 1);
        n = 1'b1;
      end
      r = OW'(q);
    end
  endfunction

  // Handshake model: busy from accept to handshake, result due LAT edges after accept.
  bit            busy;
  int unsigned   age;
  logic [OW-1:0] exp_out;
  bit            exp_norm, exp_zero;
  logic          valid_exp;
  logic [OW-1:0] m_r;
  bit            m_n, m_z;

  assign valid_exp = busy && (age >= LAT);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      age  <= 0;
    end else if (!busy) begin
      if (in_valid) begin
        model(in1, in2, 1'b1, m_r, m_n, m_z);
        busy     <= 1'b1;
        age      <= 0;
        exp_out  <= m_r;
        exp_norm <= m_n;
        exp_zero <= m_z;
      end
    end else if (valid_exp && out_ready) begin
      busy <= 1'b0;
    end else if (age < LAT) begin
      age <= age + 1;
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 64'(in_ready), 64'(!busy));
      check("out_valid", 64'(out_valid), 64'(valid_exp));
      if (valid_exp) begin
        check("out", 64'(out), 64'(exp_out));
        check("norm", 64'(norm), 64'(exp_norm));
        check("zero", 64'(zero), 64'(exp_zero));
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check("wait_idle_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic run_main(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] eo,
                          input bit en, input bit ez, input int hold);
    int n = 0;
    wait_idle();
    in1 = a; in2 = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = W'($urandom); in2 = W'($urandom);
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(LAT));
    check("lit_out", 64'(out), 64'(eo));
    check("lit_norm", 64'(norm), 64'(en));
    check("lit_zero", 64'(zero), 64'(ez));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      check("hold_out", 64'(out), 64'(eo));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = (hold != 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_alt(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] eo,
                         input bit en, input bit ez);
    int n = 0;
    check("alt_in_ready", 64'(a_in_ready), 64'd1);
    a_in1 = a; a_in2 = b; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in1 = W'($urandom); a_in2 = W'($urandom);
    while (!a_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("alt_latency", 64'(n), 64'(ALT_LAT));
    check("alt_out", 64'(a_out), 64'(eo));
    check("alt_norm", 64'(a_norm), 64'(en));
    check("alt_zero", 64'(a_zero), 64'(ez));
    @(posedge clk); #1;
    check("alt_post_hs_valid", 64'(a_out_valid), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    int unsigned s = $urandom_range(0, 7);
    if (s == 0) return '0;
    if (s == 1) return '1;
    if (s == 2) return {1'b1, 23'($urandom)};
    return W'($urandom);
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;
    a_in_valid = 1'b0; a_in1 = '0; a_in2 = '0; a_out_ready = 1'b0;

    // Pin the model with hand-computed values.
    model(24'h800000, 24'h800000, 1'b1, m_r, m_n, m_z);
    check("model_c1", {m_r, 30'd0, m_n, m_z}, {32'h80000000, 32'd0});
    model(24'hFFFFFF, 24'hFFFFFF, 1'b1, m_r, m_n, m_z);
    check("model_c2", {m_r, 30'd0, m_n, m_z}, {32'hFFFFFE00, 32'd2});
    model(24'hFFFFFF, 24'h800001, 1'b1, m_r, m_n, m_z);
    check("model_c3_rne", {m_r, 30'd0, m_n, m_z}, {32'h80000080, 32'd2});
    model(24'hFFFFFF, 24'h800001, 1'b0, m_r, m_n, m_z);
    check("model_c3_trunc", {m_r, 30'd0, m_n, m_z}, {32'h8000007F, 32'd2});

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_norm", 64'(norm), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_main(24'h800000, 24'h800000, 32'h80000000, 1'b0, 1'b0, 0);
    run_main(24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFE00, 1'b1, 1'b0, 0);
    run_main(24'hFFFFFF, 24'h800001, 32'h80000080, 1'b1, 1'b0, 0);
    run_main(24'h000000, 24'hABCDEF, 32'h00000000, 1'b0, 1'b1, 0);
    run_main(24'h800000, 24'h800000, 32'h80000000, 1'b0, 1'b0, 10);

    run_alt(24'hFFFFFF, 24'h800001, 32'h8000007F, 1'b1, 1'b0);
    run_alt(24'h000000, 24'hABCDEF, 32'h00000000, 1'b0, 1'b1);

    // Reset in the middle of CALC discards the operation.
    wait_idle();
    in1 = 24'h800000; in2 = 24'h800000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_main(24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFE00, 1'b1, 1'b0, 0);

    // Random back-to-back operands with random back-pressure.
    for (int t = 0; t < 1500; t++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in1       = pick();
      in2       = pick();
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
